five_operand_accum_ctrl: RTL and testbench

FIVE_OPERAND_ACCUM_CTRL -- requirements
Module: five_operand_accum_ctrl

---
 rtl/five_operand_accum_ctrl_pkg.sv | 16 +
 rtl/five_operand_accum_ctrl_sync_edge_detect.sv | 29 ++
 rtl/five_operand_accum_ctrl.sv | 151 +++++++++++++++
 tb/tb_five_operand_accum_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/five_operand_accum_ctrl_pkg.sv
// Shared constants and FSM state type for the five-operand accumulator controller.
package five_operand_accum_ctrl_pkg;

   localparam int OP_W  = 4;
   localparam int N_OPS = 5;
   localparam int SUM_W = 6;
   localparam int ACC_W = 7;
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/five_operand_accum_ctrl_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level input, with a single-cycle
// pulse on the synchronized rising edge.
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Synchronizer chain plus the previous-sample register used for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/five_operand_accum_ctrl.sv
// Five-operand accumulator controller: push buttons load operand slots, rc loads
// the last slot and starts a serial sum through one shared adder.
//
// state | meaning
// IDLE  | slots accept loads from pb1..pb4 / rc
// ACCUM | one slot added per cycle, index 0..N_OPS-1
// DONE  | sum/carry just updated, done pulse; slots clear on exit
module five_operand_accum_ctrl #(
   parameter int OP_W  = five_operand_accum_ctrl_pkg::OP_W,
   parameter int N_OPS = five_operand_accum_ctrl_pkg::N_OPS
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pb1,
   input  logic            pb2,
   input  logic            pb3,
   input  logic            pb4,
   input  logic            rc,
   input  logic [OP_W-1:0] in,
   output logic [5:0]      sum,
   output logic            carry,
   output logic            busy,
   output logic            done
);
   import five_operand_accum_ctrl_pkg::*;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OPS - 1);

   logic                  r_rst_meta;
   logic                  r_rst_sync;
   logic                  w_rst_n;
   logic [N_OPS-1:0]      w_btn;
   logic [N_OPS-1:0]      w_rise;
   logic [OP_W-1:0]       r_in_meta;
   logic [OP_W-1:0]       r_in_sync;
   logic [OP_W-1:0]       r_slot [N_OPS];
   logic [N_OPS-1:0]      r_loaded;
   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_idx;
   logic [ACC_W-1:0]      r_acc;
   logic [ACC_W-1:0]      w_addend;
   logic [ACC_W-1:0]      w_acc_nxt;
   logic                  w_start;
   logic [SUM_W-1:0]      r_sum;
   logic                  r_carry;

   // Reset asserts immediately but releases two clocks after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   assign w_rst_n = r_rst_sync;

   // Bit N_OPS-1 is rc, which owns the last slot.
   assign w_btn = {rc, pb4, pb3, pb2, pb1};

   for (genvar g = 0; g < N_OPS; g++) begin : g_btn
      sync_edge_detect u_sync (
         .clk     (clk),
         .rst_n   (w_rst_n),
         .i_async (w_btn[g]),
         .o_rise  (w_rise[g])
      );
   end

   // Operand bus synchronizer, same latency as the button path so data lines up with the edge.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_in_meta <= '0;
         r_in_sync <= '0;
      end else begin
         r_in_meta <= in;
         r_in_sync <= r_in_meta;
      end
   end

   assign w_start = (r_state == IDLE) && w_rise[N_OPS-1];

   // Slot loads only in IDLE; everything is wiped as DONE hands back to IDLE.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int k = 0; k < N_OPS; k++) r_slot[k] <= '0;
         r_loaded <= '0;
      end else if (r_state == DONE) begin
         for (int k = 0; k < N_OPS; k++) r_slot[k] <= '0;
         r_loaded <= '0;
      end else if (r_state == IDLE) begin
         for (int k = 0; k < N_OPS; k++) begin
            if (w_rise[k]) begin
               r_slot[k]   <= r_in_sync;
               r_loaded[k] <= 1'b1;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_nxt = ACCUM;
         ACCUM:   if (r_idx == IDX_LAST) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_addend  = r_loaded[r_idx] ? ACC_W'(r_slot[r_idx]) : '0;
   assign w_acc_nxt = r_acc + w_addend;

   // Serial accumulation; result registers latch on the last add and hold until the next run.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_acc   <= '0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else if (w_start) begin
         r_acc <= '0;
         r_idx <= '0;
      end else if (r_state == ACCUM) begin
         r_acc <= w_acc_nxt;
         if (r_idx == IDX_LAST) begin
            r_idx   <= '0;
            r_sum   <= w_acc_nxt[SUM_W-1:0];
            r_carry <= w_acc_nxt[ACC_W-1];
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign sum   = r_sum;
   assign carry = r_carry;
   assign busy  = (r_state != IDLE);
   assign done  = (r_state == DONE);

endmodule

// File: tb/tb_five_operand_accum_ctrl.sv
// Bench for five_operand_accum_ctrl: table of load/rc vectors, randomized runs
// against a slot-array model, and hand sequences for reset and ignored presses.
module tb_five_operand_accum_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pb1 = 1'b0, pb2 = 1'b0, pb3 = 1'b0, pb4 = 1'b0, rc = 1'b0;
   logic [3:0] in_v = 4'd0;
   logic [5:0] sum;
   logic       carry, busy, done;

   int n_vec = 0;
   int n_err = 0;
   int m_slot [4];

   typedef struct {
      logic [15:0] masks;   // four press steps, nibble s = button mask of step s (bit0 = pb1)
      logic [15:0] vals;    // nibble s = in value for step s
      logic [3:0]  rc_val;
      int          exp_sum;
      int          exp_carry;
   } vec_t;

   vec_t tbl [7];

   always #5 clk = ~clk;

   five_operand_accum_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pb1   (pb1),
      .pb2   (pb2),
      .pb3   (pb3),
      .pb4   (pb4),
      .rc    (rc),
      .in    (in_v),
      .sum   (sum),
      .carry (carry),
      .busy  (busy),
      .done  (done)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int s = 0; s < 4; s++) m_slot[s] = 0;
   endtask

   task automatic press(input logic [3:0] mask, input logic [3:0] val);
      in_v = val;
      {pb4, pb3, pb2, pb1} = mask;
      repeat (4) @(negedge clk);
      {pb4, pb3, pb2, pb1} = 4'b0;
      repeat (4) @(negedge clk);
      for (int s = 0; s < 4; s++) if (mask[s]) m_slot[s] = int'(val);
   endtask

   // rc edge is seen 2 clocks after driving; ACCUM spans edges 3..7, DONE after edge 8.
   task automatic run_rc(input logic [3:0] val, input int exp_sum, input int exp_carry,
                         input string tag);
      int done_k, n_done;
      bit busy_ok;
      done_k = -1; n_done = 0; busy_ok = 1'b1;
      in_v = val;
      rc = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            n_done++;
            if (done_k < 0) done_k = k;
         end
         if (busy !== ((k >= 3) && (k <= 8))) busy_ok = 1'b0;
      end
      chk({tag, "_done_cycle"}, done_k, 8);
      chk({tag, "_done_count"}, n_done, 1);
      chk({tag, "_busy_window"}, int'(busy_ok), 1);
      chk({tag, "_sum"}, int'(sum), exp_sum);
      chk({tag, "_carry"}, int'(carry), exp_carry);
      rc = 1'b0;
      repeat (4) @(negedge clk);
      clear_model();
   endtask

   task automatic apply_vec(input int i);
      for (int s = 0; s < 4; s++)
         if (tbl[i].masks[4*s +: 4] != 4'b0)
            press(tbl[i].masks[4*s +: 4], tbl[i].vals[4*s +: 4]);
      run_rc(tbl[i].rc_val, tbl[i].exp_sum, tbl[i].exp_carry, $sformatf("vec%0d", i));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_done, total, busy_seen;
      logic [3:0] mask, val, rcv;

      tbl[0] = '{masks: 16'h8421, vals: 16'hEDCB, rc_val: 4'd15, exp_sum: 1,  exp_carry: 1};
      tbl[1] = '{masks: 16'h0002, vals: 16'h0009, rc_val: 4'd3,  exp_sum: 12, exp_carry: 0};
      tbl[2] = '{masks: 16'h0005, vals: 16'h0007, rc_val: 4'd0,  exp_sum: 14, exp_carry: 0};
      tbl[3] = '{masks: 16'h0011, vals: 16'h003F, rc_val: 4'd4,  exp_sum: 7,  exp_carry: 0};
      tbl[4] = '{masks: 16'h000F, vals: 16'h000F, rc_val: 4'd15, exp_sum: 11, exp_carry: 1};
      tbl[5] = '{masks: 16'h0000, vals: 16'h0000, rc_val: 4'd0,  exp_sum: 0,  exp_carry: 0};
      tbl[6] = '{masks: 16'h0048, vals: 16'h009A, rc_val: 4'd15, exp_sum: 34, exp_carry: 0};
      clear_model();

      // Reset state, with pb1 held through reset release.
      pb1 = 1'b1;
      in_v = 4'd6;
      repeat (3) @(negedge clk);
      chk("rst_sum", int'(sum), 0);
      chk("rst_carry", int'(carry), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      pb1 = 1'b0;
      repeat (4) @(negedge clk);
      m_slot[0] = 6;
      run_rc(4'd0, 6, 0, "post_reset_load");

      for (int i = 0; i < 7; i++) apply_vec(i);

      // Press during ACCUM is ignored and slots are empty for the next run.
      press(4'b0010, 4'd9);
      in_v = 4'd3;
      rc = 1'b1;
      n_done = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 4) begin
            pb1 = 1'b1;
            in_v = 4'd5;
         end
         if (done) n_done++;
      end
      chk("accum_press_done_count", n_done, 1);
      chk("accum_press_sum", int'(sum), 12);
      rc = 1'b0;
      repeat (3) @(negedge clk);
      pb1 = 1'b0;
      repeat (4) @(negedge clk);
      clear_model();
      run_rc(4'd2, 2, 0, "ignored_press");

      // Reset pulse mid-ACCUM aborts the run.
      press(4'hF, 4'd15);
      in_v = 4'd15;
      rc = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_sum", int'(sum), 0);
      chk("abort_carry", int'(carry), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      repeat (2) @(negedge clk);
      rc = 1'b0;
      rst_n = 1'b1;
      n_done = 0;
      busy_seen = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (done) n_done++;
         if (busy) busy_seen++;
      end
      chk("abort_no_done", n_done, 0);
      chk("abort_no_busy", busy_seen, 0);
      chk("abort_sum_after", int'(sum), 0);
      clear_model();
      apply_vec(0);

      // rc held for 20 cycles gives one result only.
      in_v = 4'd9;
      rc = 1'b1;
      n_done = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      rc = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("rc_hold_done_count", n_done, 1);
      chk("rc_hold_sum", int'(sum), 9);
      clear_model();

      // Randomized runs against the slot model.
      for (int r = 0; r < 20; r++) begin
         for (int s = 0; s < 4; s++) begin
            mask = 4'($urandom_range(0, 15));
            val  = 4'($urandom_range(0, 15));
            if (mask != 4'b0) press(mask, val);
         end
         rcv = 4'($urandom_range(0, 15));
         total = int'(rcv);
         for (int s = 0; s < 4; s++) total += m_slot[s];
         run_rc(rcv, total % 64, total / 64, $sformatf("rand%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
